// File: rtl/mcu_regs_pkg.sv
// Shared definitions for the MCU register window: register indices, status
// bit positions, screen geometry defaults and the pixel-reader FSM states.
package mcu_regs_pkg;

  localparam int unsigned SCREEN_WIDTH_DEF  = 320;
  localparam int unsigned SCREEN_HEIGHT_DEF = 240;
  localparam int unsigned SYNC_STAGES_DEF   = 3;

  localparam int unsigned X_W    = 9;
  localparam int unsigned Y_W    = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;

  // Indices 0-2 belong to the write path; 3-7 are shared with the reader.
  localparam logic [SEL_W-1:0] REG_WR0    = 3'd0;
  localparam logic [SEL_W-1:0] REG_WR1    = 3'd1;
  localparam logic [SEL_W-1:0] REG_WR2    = 3'd2;
  localparam logic [SEL_W-1:0] REG_PIXEL  = 3'd3;
  localparam logic [SEL_W-1:0] REG_STATUS = 3'd4;
  localparam logic [SEL_W-1:0] REG_XLO    = 3'd5;
  localparam logic [SEL_W-1:0] REG_XHI    = 3'd6;
  localparam logic [SEL_W-1:0] REG_Y      = 3'd7;

  localparam int unsigned STATUS_BUSY_BIT  = 0;
  localparam int unsigned STATUS_VALID_BIT = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } rd_coord_t;

endpackage

// File: rtl/mcu_strobe_sync.sv
// Synchronizes an asynchronous MCU strobe into the clock domain and flags the
// end of the access as a one-cycle pulse on the falling edge of the last stages.
module mcu_strobe_sync #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  output logic level_o,
  output logic fall_c_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], strobe_i};
    end
  end

  // Second stage is stable enough to qualify shadow sampling.
  assign level_o  = sync_q[1];
  assign fall_c_o = sync_q[STAGES-1] & ~sync_q[STAGES-2];

endmodule

// File: rtl/mcu_pixel_reader.sv
// MCU read-back path: holds read coordinates, prefetches the pixel through the
// MemoryManager read handshake and auto-advances after each pixel read.
module mcu_pixel_reader
  import mcu_regs_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int unsigned SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mpuChipSelect,
  input  logic              mpuWriteEnable,
  input  logic [SEL_W-1:0]  mpuRegisterSelect,
  input  logic [DATA_W-1:0] mpuDataIn,
  output logic [DATA_W-1:0] mpuDataOut,
  output logic              mpuDataOutEnable,
  output logic [X_W-1:0]    memoryReadXCoord,
  output logic [Y_W-1:0]    memoryReadYCoord,
  output logic              memoryReadRequest,
  input  logic [DATA_W-1:0] memoryReadData,
  input  logic              memoryReadComplete
);

  logic wr_level, wr_end_c;
  logic rd_level, rd_end_c;

  logic [SEL_W-1:0]  wr_sel_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [SEL_W-1:0]  rd_sel_q;

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              trigger_c;

  rd_state_e         state_q;
  logic              pending_q;
  logic              valid_q;
  logic [DATA_W-1:0] pixel_q;
  logic              req_q;
  rd_coord_t         coord_q;
  logic              busy_c;

  mcu_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk_i    (clock),
    .rst_i    (reset),
    .strobe_i (mpuChipSelect & ~mpuWriteEnable),
    .level_o  (wr_level),
    .fall_c_o (wr_end_c)
  );

  mcu_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk_i    (clock),
    .rst_i    (reset),
    .strobe_i (mpuChipSelect & mpuWriteEnable),
    .level_o  (rd_level),
    .fall_c_o (rd_end_c)
  );

  // Next coordinates: auto-advance after a pixel read, then register commits.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    trigger_c = 1'b0;
    if (rd_end_c && (rd_sel_q == REG_PIXEL)) begin
      trigger_c = 1'b1;
      if (x_q >= X_W'(SCREEN_WIDTH - 1)) begin
        x_d = '0;
        y_d = (y_q >= Y_W'(SCREEN_HEIGHT - 1)) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
    if (wr_end_c) begin
      case (wr_sel_q)
        REG_XLO: x_d[7:0] = wr_data_q;
        REG_XHI: x_d[8]   = wr_data_q[0];
        REG_Y: begin
          y_d       = wr_data_q;
          trigger_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Shadow capture of the bus while a strobe is active, plus coordinate state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_sel_q  <= '0;
      wr_data_q <= '0;
      rd_sel_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      if (wr_level) begin
        wr_sel_q  <= mpuRegisterSelect;
        wr_data_q <= mpuDataIn;
      end
      if (rd_level) begin
        rd_sel_q <= mpuRegisterSelect;
      end
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Fetch FSM; a trigger during FETCH is remembered and reissued from IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      pixel_q   <= '0;
      req_q     <= 1'b0;
      coord_q   <= '0;
    end else begin
      if (trigger_c) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (trigger_c || pending_q) begin
            state_q   <= ST_FETCH;
            req_q     <= 1'b1;
            coord_q.x <= x_d;
            coord_q.y <= y_d;
            pending_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (trigger_c) begin
            pending_q <= 1'b1;
          end
          if (memoryReadComplete) begin
            pixel_q <= memoryReadData;
            valid_q <= ~(trigger_c | pending_q);
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy_c            = (state_q == ST_FETCH) || pending_q;
  assign memoryReadRequest = req_q;
  assign memoryReadXCoord  = coord_q.x;
  assign memoryReadYCoord  = coord_q.y;
  assign mpuDataOutEnable  = mpuChipSelect & mpuWriteEnable & ~reset;

  // Read mux straight from the register select pins.
  always_comb begin
    mpuDataOut = 8'hFF;
    case (mpuRegisterSelect)
      REG_PIXEL: mpuDataOut = pixel_q;
      REG_STATUS: begin
        mpuDataOut                   = '0;
        mpuDataOut[STATUS_VALID_BIT] = valid_q;
        mpuDataOut[STATUS_BUSY_BIT]  = busy_c;
      end
      REG_XLO: mpuDataOut = x_q[7:0];
      REG_XHI: mpuDataOut = {7'b0, x_q[8]};
      REG_Y:   mpuDataOut = y_q;
      default: ;
    endcase
  end

endmodule
